y86_instr_encoder: RTL and testbench

- Write-side counterpart of the sequential fetch stage.
- Accepts one decoded Y86 instruction per handshake (icode, ifun, rA, rB, valC) and serialises it into byte-wide instruction memory at a running write pointer.
- Byte layout is exactly what fetch parses: 1, 2, 9 or 10 bytes, with valC emitted MSB first.
- Used by the testbench/loader to build program images, and as the store path for self-modifying-code tests.

---
 rtl/y86_pkg.sv | 58 +++++
 rtl/y86_instr_pack.sv | 31 +++
 rtl/y86_instr_encoder.sv | 184 ++++++++++++++++++
 tb/tb_y86_instr_encoder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, field payload, length and window helpers.
package y86_pkg;

  localparam int unsigned PC_W            = 64;
  localparam int unsigned MAX_INSTR_BYTES = 10;
  localparam int unsigned WIN_W           = 8 * MAX_INSTR_BYTES;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Encoder control states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_ERR  = 2'd2
  } enc_state_e;

  // Decoded instruction fields as presented on the write side
  typedef struct packed {
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic [PC_W-1:0] valc;
  } instr_fields_t;

  // Encoded length in bytes; 0 marks an undefined icode
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    logic [3:0] len;
    case (icode)
      I_HALT, I_NOP, I_RET:                 len = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:     len = 4'd2;
      I_JXX, I_CALL:                        len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:         len = 4'd10;
      default:                              len = 4'd0;
    endcase
    return len;
  endfunction

  // Byte idx of a big-endian instruction window (byte 0 in the top bits)
  function automatic logic [7:0] win_byte(input logic [WIN_W-1:0] win,
                                          input logic [3:0]       idx);
    logic [WIN_W-1:0] sh;
    sh = win << {idx, 3'b000};
    return sh[WIN_W-1 -: 8];
  endfunction

endpackage

// File: rtl/y86_instr_pack.sv
// Combinational packer: decoded fields -> big-endian byte window, length, valid flag.
module y86_instr_pack
  import y86_pkg::*;
(
  input  instr_fields_t    fields_i,
  output logic [WIN_W-1:0] window_o,
  output logic [3:0]       len_o,
  output logic             valid_o
);

  // Place fields exactly where fetch expects them; unused bytes stay zero
  always_comb begin
    window_o = '0;
    case (fields_i.icode)
      I_HALT, I_NOP, I_RET:
        window_o = {fields_i.icode, fields_i.ifun, 72'h0};
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:
        window_o = {fields_i.icode, fields_i.ifun, fields_i.ra, fields_i.rb, 64'h0};
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:
        window_o = {fields_i.icode, fields_i.ifun, fields_i.ra, fields_i.rb, fields_i.valc};
      I_JXX, I_CALL:
        window_o = {fields_i.icode, fields_i.ifun, fields_i.valc, 8'h0};
      default:
        window_o = '0;
    endcase
  end

  assign len_o   = instr_len(fields_i.icode);
  assign valid_o = (fields_i.icode <= I_POPQ);

endmodule

// File: rtl/y86_instr_encoder.sv
// Serialises one decoded Y86 instruction per handshake into byte-wide memory.
module y86_instr_encoder
  import y86_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 256,
  parameter int unsigned ADDR_W   = PC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valc,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready,
  output logic              done,
  output logic [3:0]        done_len,
  output logic [ADDR_W-1:0] next_pc,
  output logic              invalid_instr,
  output logic              mem_error
);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        len_q, len_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic [3:0]        done_len_q, done_len_d;
  logic [ADDR_W-1:0] next_pc_q, next_pc_d;
  logic              invalid_q, invalid_d;
  logic              mem_err_q, mem_err_d;

  instr_fields_t     fields;
  logic [WIN_W-1:0]  pk_win;
  logic [3:0]        pk_len;
  logic              pk_valid;
  logic [ADDR_W:0]   end_ptr;
  logic              overflow;
  logic [3:0]        idx_nxt;
  logic [ADDR_W-1:0] ptr_after;

  assign fields = {icode, ifun, rA, rB, valc};

  y86_instr_pack u_pack (
    .fields_i (fields),
    .window_o (pk_win),
    .len_o    (pk_len),
    .valid_o  (pk_valid)
  );

  // One extra bit keeps a pointer near the top of the address space from wrapping
  assign end_ptr   = {1'b0, wr_ptr_q} + (ADDR_W+1)'(pk_len);
  assign overflow  = end_ptr > (ADDR_W+1)'(MEM_SIZE);
  assign idx_nxt   = idx_q + 4'd1;
  assign ptr_after = wr_ptr_q + ADDR_W'(len_q);

  assign in_ready = (state_q == S_IDLE) && !addr_load;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      win_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      done_len_q  <= '0;
      next_pc_q   <= '0;
      invalid_q   <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      win_q       <= win_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      done_len_q  <= done_len_d;
      next_pc_q   <= next_pc_d;
      invalid_q   <= invalid_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // Next-state: accept/reject in IDLE, byte-by-byte emission in EMIT, ERR is terminal
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    idx_d       = idx_q;
    len_d       = len_q;
    win_d       = win_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    done_len_d  = done_len_q;
    next_pc_d   = next_pc_q;
    invalid_d   = invalid_q;
    mem_err_d   = mem_err_q;

    case (state_q)
      S_IDLE: begin
        if (addr_load) begin
          wr_ptr_d = addr_in;
        end else if (in_valid) begin
          if (!pk_valid) begin
            invalid_d  = 1'b1;
            done_d     = 1'b1;
            done_len_d = 4'd0;
            next_pc_d  = wr_ptr_q;
          end else if (overflow) begin
            mem_err_d  = 1'b1;
            state_d    = S_ERR;
            done_d     = 1'b1;
            done_len_d = 4'd0;
            next_pc_d  = wr_ptr_q;
          end else begin
            win_d       = pk_win;
            len_d       = pk_len;
            idx_d       = 4'd0;
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_ptr_q;
            mem_wdata_d = pk_win[WIN_W-1 -: 8];
            state_d     = S_EMIT;
          end
        end
      end

      S_EMIT: begin
        if (mem_we_q && mem_ready) begin
          if (idx_q == (len_q - 4'd1)) begin
            mem_we_d   = 1'b0;
            wr_ptr_d   = ptr_after;
            done_d     = 1'b1;
            done_len_d = len_q;
            next_pc_d  = ptr_after;
            idx_d      = 4'd0;
            state_d    = S_IDLE;
          end else begin
            idx_d       = idx_nxt;
            mem_addr_d  = wr_ptr_q + ADDR_W'(idx_nxt);
            mem_wdata_d = win_byte(win_q, idx_nxt);
          end
        end
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign done          = done_q;
  assign done_len      = done_len_q;
  assign next_pc       = next_pc_q;
  assign invalid_instr = invalid_q;
  assign mem_error     = mem_err_q;

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Scoreboard bench for y86_instr_encoder: directed instructions, expected bytes/done queued.
module tb_y86_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        addr_load;
  logic [63:0] addr_in;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valc;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready;
  logic        done;
  logic [3:0]  done_len;
  logic [63:0] next_pc;
  logic        invalid_instr;
  logic        mem_error;

  typedef struct { logic [63:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [3:0] len; logic [63:0] pc; } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  y86_instr_encoder #(.MEM_SIZE(256), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst), .addr_load(addr_load), .addr_in(addr_in),
    .in_valid(in_valid), .in_ready(in_ready), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valc(valc), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .done(done),
    .done_len(done_len), .next_pc(next_pc), .invalid_instr(invalid_instr),
    .mem_error(mem_error)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted byte and every done pulse is matched against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we && mem_ready) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("write_addr", mem_addr, w.addr);
          chk("write_data", 64'(mem_wdata), 64'(w.data));
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got len %0d pc %0h expected no done", done_len, next_pc);
        end else begin
          dn_t d;
          d = dq.pop_front();
          chk("done_len", 64'(done_len), 64'(d.len));
          chk("next_pc", next_pc, d.pc);
        end
      end
    end
  end

  // Queue n expected bytes taken MSB-first from a hand-written 80-bit image
  task automatic exp_bytes(input logic [63:0] base, input logic [79:0] img, input int n);
    logic [79:0] t;
    for (int i = 0; i < n; i++) begin
      wr_t w;
      t = img << (8 * i);
      w.addr = base + 64'(i);
      w.data = t[79:72];
      wq.push_back(w);
    end
  endtask

  task automatic exp_done(input logic [3:0] len, input logic [63:0] pc);
    dn_t d;
    d.len = len;
    d.pc  = pc;
    dq.push_back(d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ptr(input logic [63:0] a);
    addr_load = 1'b1;
    addr_in   = a;
    step();
    addr_load = 1'b0;
  endtask

  // Present an instruction and hold it until accepted; returns #1 after the accept edge
  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc);
    bit ok;
    ok = 1'b0;
    icode = ic; ifun = fn; rA = ra; rB = rb; valc = vc;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      ok = in_ready;
      step();
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready 0 expected accept of icode %0h", ic);
    end
  endtask

  // Wait for the scoreboard to empty, bounded
  task automatic drain(input string name);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (wq.size() == 0 && dq.size() == 0) break;
    end
    @(negedge clk);
    checks++;
    if (wq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d writes %0d dones pending expected 0", name, wq.size(), dq.size());
      wq.delete();
      dq.delete();
    end
    step();
  endtask

  initial begin
    int n;
    rst = 1'b1; addr_load = 1'b0; addr_in = '0; in_valid = 1'b0;
    icode = '0; ifun = '0; rA = '0; rB = '0; valc = '0; mem_ready = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_mem_we", 64'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", 64'(mem_wdata), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_done_len", 64'(done_len), 0);
    chk("rst_next_pc", next_pc, 0);
    chk("rst_invalid", 64'(invalid_instr), 0);
    chk("rst_mem_error", 64'(mem_error), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    step();
    rst = 1'b0;

    // irmovq $0x102, %rdx at 0, done 11 cycles after accept
    exp_bytes(64'h0, 80'h30F2_0000_0000_0000_0102, 10);
    exp_done(4'd10, 64'd10);
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h102);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk("irmovq_done_latency", 64'(n), 64'd11);
    drain("irmovq");

    // call 0x40 after pointer load to 0x20
    addr_load = 1'b1; addr_in = 64'h20;
    @(negedge clk);
    chk("in_ready_during_load", 64'(in_ready), 0);
    step();
    addr_load = 1'b0;
    exp_bytes(64'h20, 80'h8000_0000_0000_0000_4000, 9);
    exp_done(4'd9, 64'h29);
    send(4'h8, 4'h0, 4'h0, 4'h0, 64'h40);
    drain("call");

    // nop, addq %rcx,%rdx, ret back to back
    load_ptr(64'h0);
    exp_bytes(64'h0, 80'h1000_0000_0000_0000_0000, 1);
    exp_done(4'd1, 64'd1);
    exp_bytes(64'h1, 80'h6012_0000_0000_0000_0000, 2);
    exp_done(4'd2, 64'd3);
    exp_bytes(64'h3, 80'h9000_0000_0000_0000_0000, 1);
    exp_done(4'd1, 64'd4);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
    send(4'h6, 4'h0, 4'h1, 4'h2, 64'h0);
    send(4'h9, 4'h0, 4'h0, 4'h0, 64'h0);
    drain("b2b");

    // rrmovq %rbx,%rsp with memory stalled on byte 1
    load_ptr(64'h0);
    exp_bytes(64'h0, 80'h2034_0000_0000_0000_0000, 2);
    exp_done(4'd2, 64'd2);
    send(4'h2, 4'h0, 4'h3, 4'h4, 64'h0);
    step();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_we", 64'(mem_we), 1);
      chk("bp_addr", mem_addr, 64'd1);
      chk("bp_data", 64'(mem_wdata), 64'h34);
      step();
    end
    mem_ready = 1'b1;
    drain("backpressure");

    // mrmovq exactly filling the last 10 bytes
    load_ptr(64'd246);
    exp_bytes(64'd246, 80'h5034_1122_3344_5566_7788, 10);
    exp_done(4'd10, 64'd256);
    send(4'h5, 4'h0, 4'h3, 4'h4, 64'h1122_3344_5566_7788);
    drain("boundary_fit");

    // undefined icode 0xC, then a nop is still accepted
    load_ptr(64'h10);
    exp_done(4'd0, 64'h10);
    send(4'hC, 4'h0, 4'h0, 4'h0, 64'h0);
    drain("invalid");
    chk("invalid_sticky", 64'(invalid_instr), 1);
    exp_bytes(64'h10, 80'h1000_0000_0000_0000_0000, 1);
    exp_done(4'd1, 64'h11);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
    drain("after_invalid");
    chk("invalid_still_set", 64'(invalid_instr), 1);

    // reset while byte 4 of irmovq is on the bus
    load_ptr(64'h40);
    exp_bytes(64'h40, 80'h30F5_AABB_CCDD_EEFF_0011, 4);
    send(4'h3, 4'h0, 4'hF, 4'h5, 64'hAABB_CCDD_EEFF_0011);
    repeat (4) step();
    chk("pre_rst_addr", mem_addr, 64'h44);
    rst = 1'b1;
    step();
    chk("midrst_mem_we", 64'(mem_we), 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_wdata", 64'(mem_wdata), 0);
    chk("midrst_done", 64'(done), 0);
    chk("midrst_next_pc", next_pc, 0);
    chk("midrst_invalid", 64'(invalid_instr), 0);
    chk("midrst_in_ready", 64'(in_ready), 1);
    rst = 1'b0;
    drain("midrst");

    // mrmovq one byte past the end: rejected, terminal error state
    load_ptr(64'd247);
    exp_done(4'd0, 64'd247);
    send(4'h5, 4'h0, 4'h3, 4'h4, 64'h0);
    @(negedge clk);
    chk("err_mem_error", 64'(mem_error), 1);
    chk("err_in_ready", 64'(in_ready), 0);
    step();
    load_ptr(64'h0);
    icode = 4'h1; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("err_hold_in_ready", 64'(in_ready), 0);
      step();
    end
    in_valid = 1'b0;
    drain("err");
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("err_clear_mem_error", 64'(mem_error), 0);
    chk("err_clear_in_ready", 64'(in_ready), 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
